// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin merge of NUM_CH AXI-Stream sources onto one RGMII TX stream,
// with inter-frame gap and stalled-source abort. Define ETH_TX_ARB_STATS_EN for frame/abort counters.
module eth_tx_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int IDLE_GAP        = 12,
  parameter int WATCH_DOG_WIDTH = 12,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tx_data,
  input  logic [NUM_CH-1:0]            s_tx_valid,
  input  logic [NUM_CH-1:0]            s_tx_last,
  input  logic [NUM_CH-1:0]            s_tx_user,
  output logic [NUM_CH-1:0]            s_tx_ready,
  output logic [DATA_WIDTH-1:0]        rgmii_tx_data,
  output logic                         rgmii_tx_valid,
  output logic                         rgmii_tx_last,
  output logic                         rgmii_tx_user,
  input  logic                         rgmii_tx_ready,
  output logic [CH_W-1:0]              grant_ch,
  output logic                         busy,
  output logic                         abort_pulse
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]         frame_cnt,
  output logic [15:0]                  abort_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, XFER, ABORT, DRAIN, GAP} state_t;

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [WATCH_DOG_WIDTH-1:0] WD_TRIP = ~WATCH_DOG_WIDTH'(1);
  localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

  state_t                     state, state_nxt;
  logic [CH_W-1:0]            ptr, ptr_nxt, grant_nxt, sel_ch, cand;
  logic                       sel_found;
  logic [GAP_W-1:0]           gap_cnt, gap_nxt;
  logic [WATCH_DOG_WIDTH-1:0] wd_cnt, wd_nxt;
  logic                       g_valid, g_last, g_user, g_acc;
  logic [DATA_WIDTH-1:0]      g_data;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_ch == CH_W'(i)) g_data = s_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_valid = s_tx_valid[grant_ch];
  assign g_last  = s_tx_last[grant_ch];
  assign g_user  = s_tx_user[grant_ch];
  assign g_acc   = g_valid & rgmii_tx_ready;
  assign busy    = (state != IDLE);

  // Descending scan so the nearest channel after ptr is the last (winning) assignment.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_W'((int'(ptr) + k) % NUM_CH);
      if (s_tx_valid[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_ch;
    gap_nxt   = gap_cnt;
    wd_nxt    = wd_cnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt = sel_ch;
          wd_nxt    = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (g_acc) begin
          wd_nxt = '0;
          if (g_last) begin
            ptr_nxt   = grant_ch;
            gap_nxt   = GAP_LOAD;
            state_nxt = (IDLE_GAP == 0) ? IDLE : GAP;
          end
        end else if (!g_valid) begin
          wd_nxt = wd_cnt + 1'b1;
          if (wd_cnt == WD_TRIP) begin
            wd_nxt    = '0;
            state_nxt = ABORT;
          end
        end
      end
      ABORT: begin
        if (rgmii_tx_ready) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (g_valid && g_last) begin
          ptr_nxt   = grant_ch;
          gap_nxt   = GAP_LOAD;
          state_nxt = (IDLE_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_tx_ready     = '0;
    rgmii_tx_data  = '0;
    rgmii_tx_valid = 1'b0;
    rgmii_tx_last  = 1'b0;
    rgmii_tx_user  = 1'b0;
    abort_pulse    = 1'b0;
    case (state)
      XFER: begin
        s_tx_ready[grant_ch] = rgmii_tx_ready;
        rgmii_tx_data        = g_data;
        rgmii_tx_valid       = g_valid;
        rgmii_tx_last        = g_last;
        rgmii_tx_user        = g_user;
      end
      ABORT: begin
        rgmii_tx_valid = 1'b1;
        rgmii_tx_last  = 1'b1;
        rgmii_tx_user  = 1'b1;
        abort_pulse    = rgmii_tx_ready;
      end
      DRAIN:   s_tx_ready[grant_ch] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      grant_ch <= '0;
      gap_cnt  <= '0;
      wd_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_ch <= grant_nxt;
      gap_cnt  <= gap_nxt;
      wd_cnt   <= wd_nxt;
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == XFER && g_acc && g_last && grant_ch == CH_W'(i))
          frame_cnt[i*16 +: 16] <= frame_cnt[i*16 +: 16] + 16'd1;
      end
      if (abort_pulse && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: queue-based sources, beat-order scoreboard with round-robin model,
// plus directed timing checks; a second instance covers IDLE_GAP = 0.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
  localparam int NUM_CH   = 4;
  localparam int DW       = 8;
  localparam int IDLE_GAP = 12;
  localparam int WDW      = 12;

  typedef struct packed { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct packed { logic [1:0] ch; logic [7:0] data; logic last; logic user; logic is_abort; } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst;

  logic [NUM_CH*DW-1:0] s_tx_data;
  logic [NUM_CH-1:0]    s_tx_valid, s_tx_last, s_tx_user, s_tx_ready;
  logic [DW-1:0]        rgmii_tx_data;
  logic                 rgmii_tx_valid, rgmii_tx_last, rgmii_tx_user, rgmii_tx_ready;
  logic [1:0]           grant_ch;
  logic                 busy, abort_pulse;

  logic [NUM_CH*DW-1:0] g_s_data;
  logic [NUM_CH-1:0]    g_s_valid, g_s_last, g_s_user, g_s_ready;
  logic [DW-1:0]        g_m_data;
  logic                 g_m_valid, g_m_last, g_m_user, g_m_ready;
  logic [1:0]           g_grant;
  logic                 g_busy, g_abort;
`ifdef ETH_TX_ARB_STATS_EN
  logic [NUM_CH*16-1:0] frame_cnt, g_frame_cnt;
  logic [15:0]          abort_cnt, g_abort_cnt;
`endif

  eth_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .IDLE_GAP(IDLE_GAP), .WATCH_DOG_WIDTH(WDW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_last(s_tx_last), .s_tx_user(s_tx_user),
    .s_tx_ready(s_tx_ready),
    .rgmii_tx_data(rgmii_tx_data), .rgmii_tx_valid(rgmii_tx_valid), .rgmii_tx_last(rgmii_tx_last),
    .rgmii_tx_user(rgmii_tx_user), .rgmii_tx_ready(rgmii_tx_ready),
    .grant_ch(grant_ch), .busy(busy), .abort_pulse(abort_pulse)
`ifdef ETH_TX_ARB_STATS_EN
    , .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
`endif
  );

  eth_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .IDLE_GAP(0), .WATCH_DOG_WIDTH(WDW)) dut_g0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_tx_data(g_s_data), .s_tx_valid(g_s_valid), .s_tx_last(g_s_last), .s_tx_user(g_s_user),
    .s_tx_ready(g_s_ready),
    .rgmii_tx_data(g_m_data), .rgmii_tx_valid(g_m_valid), .rgmii_tx_last(g_m_last),
    .rgmii_tx_user(g_m_user), .rgmii_tx_ready(g_m_ready),
    .grant_ch(g_grant), .busy(g_busy), .abort_pulse(g_abort)
`ifdef ETH_TX_ARB_STATS_EN
    , .frame_cnt(g_frame_cnt), .abort_cnt(g_abort_cnt)
`endif
  );

  initial forever #5 sys_clk = ~sys_clk;

  beat_t src_q[2][NUM_CH][$];
  exp_t  exp_q[$];
  int    acc_cyc[$], acc_ch[$], g_acc_cyc[$];
  logic [7:0] acc_data[$], g_acc_data[$];
  int    cyc, busy_cnt, abort_seen, errors, checks, c0;
  logic  rdy_mode, tgl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_CH-1:0] req, input int p);
    logic [1:0] idx;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = 2'((p + k) % NUM_CH);
      if (req[idx]) return int'(idx);
    end
    return -1;
  endfunction

  task automatic drive();
    beat_t b;
    logic [4:0] base;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      base = {ch[1:0], 3'b000};
      if (src_q[0][ch].size() > 0) b = src_q[0][ch][0]; else b = '0;
      s_tx_valid[ch[1:0]] = (src_q[0][ch].size() > 0);
      s_tx_data[base +: DW] = b.data;
      s_tx_last[ch[1:0]] = b.last;
      s_tx_user[ch[1:0]] = b.user;
      if (src_q[1][ch].size() > 0) b = src_q[1][ch][0]; else b = '0;
      g_s_valid[ch[1:0]] = (src_q[1][ch].size() > 0);
      g_s_data[base +: DW] = b.data;
      g_s_last[ch[1:0]] = b.last;
      g_s_user[ch[1:0]] = b.user;
    end
    rgmii_tx_ready = rdy_mode ? tgl : 1'b1;
    g_m_ready = 1'b1;
  endtask

  task automatic push_frame(input int inst, input int ch, input int n, input logic [7:0] d0,
                            input logic [7:0] st, input bit with_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = d0 + 8'(k) * st;
      b.last = with_last && (k == n - 1);
      b.user = 1'b0;
      src_q[inst][ch].push_back(b);
    end
  endtask

  task automatic expect_frame(input int ch, input int n, input logic [7:0] d0,
                              input logic [7:0] st, input bit with_last);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ch = 2'(ch); e.data = d0 + 8'(k) * st; e.last = with_last && (k == n - 1);
      e.user = 1'b0; e.is_abort = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_abort(input int ch);
    exp_t e;
    e.ch = 2'(ch); e.data = 8'h00; e.last = 1'b1; e.user = 1'b1; e.is_abort = 1'b1;
    exp_q.push_back(e);
  endtask

  // Per-cycle comparison of the main instance against the expected beat stream.
  task automatic model_check();
    exp_t e;
    logic [NUM_CH-1:0] others;
    if (busy) busy_cnt++;
    if (abort_pulse) abort_seen++;
    others = s_tx_ready & ~(4'b0001 << grant_ch);
    check("ready_non_granted", 32'(others), 32'd0);
    if (rgmii_tx_valid) begin
      check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("beat_ch_data_last_user", 32'({grant_ch, rgmii_tx_data, rgmii_tx_last, rgmii_tx_user}),
              32'({e.ch, e.data, e.last, e.user}));
        check("abort_pulse", 32'(abort_pulse), 32'(rgmii_tx_ready && e.is_abort));
        if (rgmii_tx_ready) begin
          acc_cyc.push_back(cyc);
          acc_ch.push_back(int'(grant_ch));
          acc_data.push_back(rgmii_tx_data);
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("abort_pulse_idle", 32'(abort_pulse), 32'd0);
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] hs, ghs;
    @(negedge sys_clk);
    model_check();
    hs  = s_tx_valid & s_tx_ready;
    ghs = g_s_valid & g_s_ready;
    if (g_m_valid && g_m_ready) begin
      g_acc_cyc.push_back(cyc);
      g_acc_data.push_back(g_m_data);
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (hs[ch[1:0]] && src_q[0][ch].size() > 0) void'(src_q[0][ch].pop_front());
      if (ghs[ch[1:0]] && src_q[1][ch].size() > 0) void'(src_q[1][ch].pop_front());
    end
    tgl = ~tgl;
    drive();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < NUM_CH; ch++) src_q[i][ch].delete();
    exp_q.delete();
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_ch.delete(); acc_data.delete();
    g_acc_cyc.delete(); g_acc_data.delete();
    busy_cnt = 0; abort_seen = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    clear_sources();
    drive();
    step(); step();
    sys_rst = 1'b0;
    step();
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() > 0) || busy || g_busy;
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < NUM_CH; ch++) if (src_q[i][ch].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_until_idle(input string name, input int max_cyc);
    int n = 0;
    while (pending() && n < max_cyc) begin
      step();
      n++;
    end
    check(name, 32'(pending()), 32'd0);
  endtask

  initial begin
    logic [NUM_CH-1:0] req;
    int p, ch;
    errors = 0; checks = 0; cyc = 0; rdy_mode = 1'b0; tgl = 1'b0;
    busy_cnt = 0; abort_seen = 0;
    sys_rst = 1'b1;
    clear_sources();
    drive();
    #1;
    check("rst_valid", 32'(rgmii_tx_valid), 32'd0);
    check("rst_ready", 32'(s_tx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_ch), 32'd0);
    repeat (3) step();
    sys_rst = 1'b0;
    step(); step();

    // Single 4-byte frame on channel 1
    clear_logs();
    push_frame(0, 1, 4, 8'h11, 8'h11, 1'b1);
    expect_frame(1, 4, 8'h11, 8'h11, 1'b1);
    drive();
    c0 = cyc;
    repeat (20) step();
    check("t1_first_latency", 32'(acc_cyc[0] - c0), 32'd1);
    check("t1_last_cycle", 32'(acc_cyc[3] - c0), 32'd4);
    check("t1_last_data", 32'(acc_data[3]), 32'h44);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd16);
    check("t1_grant_hold", 32'(grant_ch), 32'd1);
    check("t1_all_delivered", 32'(exp_q.size()), 32'd0);

    // Three simultaneous requesters after reset
    do_reset();
    clear_logs();
    req = 4'b1101;
    p = NUM_CH - 1;
    for (int i = 0; i < 3; i++) begin
      ch = rr_pick(req, p);
      push_frame(0, ch, 2, 8'(ch * 16 + 1), 8'h01, 1'b1);
      expect_frame(ch, 2, 8'(ch * 16 + 1), 8'h01, 1'b1);
      req[2'(ch)] = 1'b0;
      p = ch;
    end
    drive();
    c0 = cyc;
    run_until_idle("t2_timeout", 200);
    check("t2_order0", 32'(acc_ch[0]), 32'd0);
    check("t2_order1", 32'(acc_ch[2]), 32'd2);
    check("t2_order2", 32'(acc_ch[4]), 32'd3);
    check("t2_first_latency", 32'(acc_cyc[0] - c0), 32'd1);
    check("t2_spacing_a", 32'(acc_cyc[2] - acc_cyc[1]), 32'(IDLE_GAP + 2));
    check("t2_spacing_b", 32'(acc_cyc[4] - acc_cyc[3]), 32'(IDLE_GAP + 2));

    // 64-byte frame on channel 2 with sink ready toggling every cycle
    clear_logs();
    rdy_mode = 1'b1;
    push_frame(0, 2, 64, 8'h00, 8'h01, 1'b1);
    expect_frame(2, 64, 8'h00, 8'h01, 1'b1);
    drive();
    run_until_idle("t3_timeout", 400);
    check("t3_beat_count", 32'(acc_cyc.size()), 32'd64);
    check("t3_no_abort", 32'(abort_seen), 32'd0);
    rdy_mode = 1'b0;
    drive();

    // Channel 0 stalls mid-frame long enough to trip the watchdog; channel 1 waits
    do_reset();
    clear_logs();
    push_frame(0, 0, 3, 8'hA0, 8'h01, 1'b0);
    expect_frame(0, 3, 8'hA0, 8'h01, 1'b0);
    expect_abort(0);
    expect_frame(1, 2, 8'hB0, 8'h01, 1'b1);
    drive();
    c0 = cyc;
    for (int i = 1; i <= 4099; i++) begin
      step();
      if (i == 100) begin
        push_frame(0, 1, 2, 8'hB0, 8'h01, 1'b1);
        drive();
      end
    end
    push_frame(0, 0, 3, 8'hA3, 8'h01, 1'b1);
    drive();
    run_until_idle("t4_timeout", 200);
    check("t4_abort_after_stall", 32'(acc_cyc[3] - acc_cyc[2]), 32'd4096);
    check("t4_abort_pulses", 32'(abort_seen), 32'd1);
    check("t4_next_channel", 32'(acc_ch[4]), 32'd1);
    check("t4_next_latency", 32'(acc_cyc[4] - acc_cyc[3]), 32'd17);

    // Back-to-back frames on the IDLE_GAP = 0 instance
    clear_logs();
    push_frame(1, 0, 2, 8'hC0, 8'h01, 1'b1);
    push_frame(1, 1, 2, 8'hD0, 8'h01, 1'b1);
    drive();
    c0 = cyc;
    run_until_idle("t5_timeout", 50);
    check("t5_beat_count", 32'(g_acc_cyc.size()), 32'd4);
    check("t5_first_latency", 32'(g_acc_cyc[0] - c0), 32'd1);
    check("t5_back_to_back", 32'(g_acc_cyc[2] - g_acc_cyc[1]), 32'd2);
    check("t5_second_data", 32'(g_acc_data[2]), 32'hD0);
    check("t5_grant", 32'(g_grant), 32'd1);

    // Reset asserted mid-frame, then channel 0 must win again
    clear_logs();
    push_frame(0, 2, 8, 8'hE0, 8'h01, 1'b1);
    expect_frame(2, 8, 8'hE0, 8'h01, 1'b1);
    drive();
    repeat (3) step();
    #2 sys_rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(rgmii_tx_valid), 32'd0);
    check("t6_async_ready", 32'(s_tx_ready), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_grant", 32'(grant_ch), 32'd0);
    clear_sources();
    drive();
    step(); step();
    sys_rst = 1'b0;
    step();
    clear_logs();
    push_frame(0, 3, 1, 8'h3C, 8'h00, 1'b1);
    push_frame(0, 0, 1, 8'h0C, 8'h00, 1'b1);
    req = 4'b1001;
    p = NUM_CH - 1;
    for (int i = 0; i < 2; i++) begin
      ch = rr_pick(req, p);
      expect_frame(ch, 1, (ch == 0) ? 8'h0C : 8'h3C, 8'h00, 1'b1);
      req[2'(ch)] = 1'b0;
      p = ch;
    end
    drive();
    c0 = cyc;
    run_until_idle("t6_timeout", 100);
    check("t6_first_ch", 32'(acc_ch[0]), 32'd0);
    check("t6_second_ch", 32'(acc_ch[1]), 32'd3);
    check("t6_first_latency", 32'(acc_cyc[0] - c0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
